seq_multiplier: RTL and testbench

//  Parametrised iterative shift-add multiplier for the ALU MULT/MULTU path.

---
 rtl/seq_multiplier_if.sv | 23 ++
 rtl/seq_multiplier.sv | 112 +++++++++++
 tb/tb_seq_multiplier.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_multiplier_if.sv
// Handshake and data bundle between an ALU request source and the iterative multiplier.
// The master issues start/operands/funct; the slave returns busy/done and the {HI,LO} product.
interface seq_multiplier_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [WIDTH-1:0]     dataA;
  logic [WIDTH-1:0]     dataB;
  logic [5:0]           Signal;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   dataOut;

  modport master (
    output start, dataA, dataB, Signal,
    input  busy, done, dataOut
  );

  modport slave (
    input  start, dataA, dataB, Signal,
    output busy, done, dataOut
  );
endinterface

// File: rtl/seq_multiplier.sv
// Iterative shift-add multiplier for MULT/MULTU: fixed WIDTH+1 cycle latency,
// sign handled by multiplying magnitudes and negating the 2*WIDTH result at the end.
module seq_multiplier #(
  parameter int WIDTH     = 32,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  seq_multiplier_if.slave  bus
);

  localparam int         CNT_W      = $clog2(WIDTH + 1);
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   mcnd_q, mcnd_d;
  logic [WIDTH-1:0]     mpr_q, mpr_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic                 neg_q, neg_d;
  logic [2*WIDTH-1:0]   data_out_q, data_out_d;
  logic                 done_q, done_d;

  logic                 accept;
  logic                 last_iter;
  logic                 sgn;
  logic [WIDTH-1:0]     mag_a;
  logic [WIDTH-1:0]     mag_b;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));
  assign sgn       = SIGNED_EN && (bus.Signal == FUNCT_MULT);
  // The magnitude of the most negative value wraps to itself, which is correct read as unsigned.
  assign mag_a     = (sgn && bus.dataA[WIDTH-1]) ? -bus.dataA : bus.dataA;
  assign mag_b     = (sgn && bus.dataB[WIDTH-1]) ? -bus.dataB : bus.dataB;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (bus.start) state_d = RUN;
      RUN:     if (last_iter) state_d = FIN;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.busy = (state_q == RUN) || (state_q == FIN);
  end

  always_comb begin
    cnt_d      = cnt_q;
    mcnd_d     = mcnd_q;
    mpr_d      = mpr_q;
    acc_d      = acc_q;
    neg_d      = neg_q;
    data_out_d = data_out_q;
    done_d     = 1'b0;
    if (accept) begin
      cnt_d  = '0;
      mcnd_d = {{WIDTH{1'b0}}, mag_a};
      mpr_d  = mag_b;
      acc_d  = '0;
      neg_d  = sgn && (bus.dataA[WIDTH-1] ^ bus.dataB[WIDTH-1]);
    end else if (state_q == RUN) begin
      acc_d  = acc_q + (mpr_q[0] ? mcnd_q : '0);
      mcnd_d = mcnd_q << 1;
      mpr_d  = mpr_q >> 1;
      cnt_d  = cnt_q + CNT_W'(1);
    end else if (state_q == FIN) begin
      data_out_d = neg_q ? -acc_q : acc_q;
      done_d     = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q      <= '0;
      mcnd_q     <= '0;
      mpr_q      <= '0;
      acc_q      <= '0;
      neg_q      <= 1'b0;
      data_out_q <= '0;
      done_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      mcnd_q     <= mcnd_d;
      mpr_q      <= mpr_d;
      acc_q      <= acc_d;
      neg_q      <= neg_d;
      data_out_q <= data_out_d;
      done_q     <= done_d;
    end
  end

  assign bus.done    = done_q;
  assign bus.dataOut = data_out_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed bench for seq_multiplier: a vector table for the 32-bit signed/unsigned
// products plus hand sequences for handshake, back-to-back, reset abort and an 8-bit unsigned build.
module tb_seq_multiplier;

  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_OTHER = 6'b100000;

  logic clk;
  logic reset;

  seq_multiplier_if #(.WIDTH(32)) bus32 ();
  seq_multiplier_if #(.WIDTH(8))  bus8 ();

  seq_multiplier #(.WIDTH(32), .SIGNED_EN(1'b1)) dut32 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus32.slave)
  );

  seq_multiplier #(.WIDTH(8), .SIGNED_EN(1'b0)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total  = 0;
  int n_passed = 0;

  task automatic check(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_total++;
    if (actual === expected) n_passed++;
    else $display("FAIL %s: got %h, expected %h", name, actual, expected);
  endtask

  typedef struct {
    string       name;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
  } vec_t;

  // Issue one request on the 32-bit unit and wait (bounded) for done; edges counts from the accepting edge.
  task automatic run32(input string name, input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                       output logic [63:0] res, output int edges);
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = f;
    bus32.dataA  = a;
    bus32.dataB  = b;
    @(negedge clk);
    bus32.start  = 1'b0;
    bus32.Signal = 6'($urandom);
    bus32.dataA  = $urandom;
    bus32.dataB  = $urandom;
    check({name, "_busy"}, 64'(bus32.busy), 64'd1);
    edges = 0;
    while (!bus32.done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    res = bus32.dataOut;
  endtask

  vec_t        vecs[10];
  logic [63:0] res;
  int          edges;
  int          extra_done;

  initial begin
    vecs[0] = '{"multu_3x5",      F_MULTU, 32'd3,          32'd5,          64'h0000_0000_0000_000F};
    vecs[1] = '{"mult_m3x5",      F_MULT,  32'hFFFF_FFFD,  32'd5,          64'hFFFF_FFFF_FFFF_FFF1};
    vecs[2] = '{"multu_m3x5",     F_MULTU, 32'hFFFF_FFFD,  32'd5,          64'h0000_0004_FFFF_FFF1};
    vecs[3] = '{"multu_max",      F_MULTU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'hFFFF_FFFE_0000_0001};
    vecs[4] = '{"mult_minneg",    F_MULT,  32'h8000_0000,  32'h8000_0000,  64'h4000_0000_0000_0000};
    vecs[5] = '{"mult_x0",        F_MULT,  32'h8765_4321,  32'd0,          64'h0};
    vecs[6] = '{"mult_7xm9",      F_MULT,  32'd7,          32'hFFFF_FFF7,  64'hFFFF_FFFF_FFFF_FFC1};
    vecs[7] = '{"other_funct",    F_OTHER, 32'hFFFF_FFFF,  32'd2,          64'h0000_0001_FFFF_FFFE};
    vecs[8] = '{"mult_m1xm1",     F_MULT,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  64'h0000_0000_0000_0001};
    vecs[9] = '{"mult_minnegx1",  F_MULT,  32'h8000_0000,  32'd1,          64'hFFFF_FFFF_8000_0000};

    reset        = 1'b0;
    bus32.start  = 1'b0;
    bus32.Signal = '0;
    bus32.dataA  = '0;
    bus32.dataB  = '0;
    bus8.start   = 1'b0;
    bus8.Signal  = '0;
    bus8.dataA   = '0;
    bus8.dataB   = '0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("reset_busy",    64'(bus32.busy), 64'd0);
    check("reset_done",    64'(bus32.done), 64'd0);
    check("reset_dataout", bus32.dataOut,   64'd0);

    for (int i = 0; i < 10; i++) begin
      run32(vecs[i].name, vecs[i].funct, vecs[i].a, vecs[i].b, res, edges);
      check(vecs[i].name, res, vecs[i].exp);
      check({vecs[i].name, "_latency"}, 64'(edges), 64'd33);
      @(negedge clk);
      check({vecs[i].name, "_done_pulse"}, 64'(bus32.done), 64'd0);
    end

    // Start held high through the whole operation with different operands.
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = F_MULTU;
    bus32.dataA  = 32'd3;
    bus32.dataB  = 32'd5;
    @(negedge clk);
    bus32.Signal = F_MULT;
    bus32.dataA  = 32'd7;
    bus32.dataB  = 32'd9;
    edges = 0;
    while (!bus32.done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    bus32.start = 1'b0;
    check("held_start_result",  bus32.dataOut, 64'h0F);
    check("held_start_latency", 64'(edges),    64'd33);
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) extra_done++;
    end
    check("held_start_one_done", 64'(extra_done), 64'd0);
    check("held_start_hold",     bus32.dataOut,   64'h0F);

    // Back-to-back: second start issued in the done cycle.
    run32("b2b_first", F_MULTU, 32'd3, 32'd5, res, edges);
    check("b2b_first", res, 64'h0F);
    bus32.start  = 1'b1;
    bus32.Signal = F_MULTU;
    bus32.dataA  = 32'd7;
    bus32.dataB  = 32'd9;
    check("b2b_done_cycle_busy", 64'(bus32.busy), 64'd0);
    @(negedge clk);
    bus32.start = 1'b0;
    check("b2b_next_busy", 64'(bus32.busy), 64'd1);
    check("b2b_next_done", 64'(bus32.done), 64'd0);
    edges = 0;
    repeat (10) begin
      @(negedge clk);
      edges++;
    end
    check("b2b_hold_during_run", bus32.dataOut, 64'h0F);
    while (!bus32.done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("b2b_second_result",  bus32.dataOut, 64'd63);
    check("b2b_second_latency", 64'(edges),    64'd33);

    // Reset dropped in the middle of an operation.
    @(negedge clk);
    bus32.start  = 1'b1;
    bus32.Signal = F_MULTU;
    bus32.dataA  = 32'h0000_ABCD;
    bus32.dataB  = 32'h0000_1234;
    @(negedge clk);
    bus32.start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    #1;
    check("abort_busy",    64'(bus32.busy), 64'd0);
    check("abort_done",    64'(bus32.done), 64'd0);
    check("abort_dataout", bus32.dataOut,   64'd0);
    @(negedge clk);
    reset = 1'b1;
    extra_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus32.done) extra_done++;
    end
    check("abort_no_done", 64'(extra_done), 64'd0);
    run32("after_abort", F_MULTU, 32'd2, 32'd2, res, edges);
    check("after_abort",         res,        64'd4);
    check("after_abort_latency", 64'(edges), 64'd33);

    // 8-bit unsigned-only build: MULT funct must still multiply unsigned.
    @(negedge clk);
    bus8.start  = 1'b1;
    bus8.Signal = F_MULT;
    bus8.dataA  = 8'hFF;
    bus8.dataB  = 8'hFF;
    @(negedge clk);
    bus8.start = 1'b0;
    edges = 0;
    while (!bus8.done && edges < 100) begin
      @(negedge clk);
      edges++;
    end
    check("w8_mult_unsigned", 64'(bus8.dataOut), 64'h0000_0000_0000_FE01);
    check("w8_latency",       64'(edges),        64'd9);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
